mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Parametrised successor to the pipeline memory stage; sits between EX/MEM and MEM/WB pipeline registers and the data cache.
- Registers each load/store into a request FSM and holds dcache_read/dcache_write until dcache_resp, stalling the pipeline meanwhile.
- Performs byte-lane alignment for stores, offset-aware sign/zero extension for loads, and misalignment detection.

Parameters:
- XLEN, 32, data/address width in bits; legal values 32 or 64.
- LANES, XLEN/8, byte lanes per cache word; derived, not overridden.
- OFFS_W, $clog2(LANES), byte-offset field width; derived.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  instruction present in stage.
- mem_read_in  in  1  load request.
- mem_write_in  in  1  store request.
- funct3_in  in  3  RV width/sign code (b, h, w, d, bu, hu, wu).
- addr_in  in  XLEN  effective byte address.
- store_data_in  in  XLEN  unshifted rs2 value.
- pipe_stall  in  1  downstream stall; instruction stays at inputs.
- dcache_rdata  in  XLEN  cache read data.
- dcache_resp  in  1  cache completion, one-cycle pulse.
- dcache_read  out  1  cache read strobe.
- dcache_write  out  1  cache write strobe.
- dcache_addr  out  XLEN  address, low OFFS_W bits forced to 0.
- dcache_wmask  out  LANES  byte enables.
- dcache_wdata  out  XLEN  lane-shifted store data.
- load_data_out  out  XLEN  extended load result, registered.
- mem_stall  out  1  stage not finished; freeze upstream.
- misalign  out  1  misaligned access flag.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs and internal registers 0.
- States IDLE, REQ, DONE.
- IDLE, valid access (valid_in & (mem_read_in | mem_write_in)):
  - Capture addr, funct3, shifted data and mask into registers.
  - Go to REQ; mem_stall=1 combinationally in this cycle.
  - Valid non-memory instruction: mem_stall=0, stay IDLE.
- REQ:
  - Exactly one of dcache_read/dcache_write high, driven from the captured registers only; mem_stall=1.
  - On dcache_resp: register the extended load result (stores leave load_data_out unchanged), then go to DONE.
- DONE:
  - mem_stall=0; strobes low.
  - pipe_stall=1: remain in DONE with load_data_out held, so no reissue.
  - pipe_stall=0: go to IDLE.
- Latency: minimum stall is 2 cycles (IDLE + 1 REQ cycle with immediate resp); cache wait cycles add 1:1.
- Store alignment:
  - wmask = base mask (b=1, h=3, w=0xF, d=0xFF) << offset, truncated to LANES.
  - wdata = store_data_in << 8*offset.
- Load extension:
  - Shift dcache_rdata right by 8*offset first, then sign- or zero-extend from 8/16/32 bits per funct3.
  - d and wu are legal only when XLEN=64; when XLEN=32 they are treated as w.
- dcache_resp in IDLE or DONE is ignored. Reset asserted in REQ abandons the access; a late resp is ignored.
- Misaligned access: h at an odd offset, w at offset not multiple of 4, d at nonzero offset. Handling is set by the optional feature.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access issues no cache strobe.
  - FSM goes IDLE->DONE directly; misalign=1 during the DONE cycle(s); load_data_out=0.
- Undefined:
  - misalign tied 0.
  - Access is issued with the word-aligned address; mask bits shifted past LANES are dropped (truncated access).

Decomposition:
- Shared package: mem_state_t enum, funct3 width constants (lb, lh, lw, ld, lbu, lhu, lwu), base-mask function.
- One sub-module, load_extend_unit: combinational shift plus extend, parametrised by XLEN.

Test Plan:
- lb, XLEN=32, addr 0x1003, rdata 0x80FF_0000, resp after 3 cycles -> dcache_read high 3 cycles, load_data_out=0xFFFF_FF80, mem_stall high 4 cycles.
- sh at addr 0x2002, data 0x0000_BEEF -> dcache_addr 0x2000, wmask 0xC, wdata 0xBEEF_0000, single write transaction.
- lw resp while pipe_stall=1 for 2 cycles -> held in DONE, no second dcache_read, load_data_out stable.
- Reset pulse during REQ, then resp -> outputs 0, state IDLE, resp ignored.
- With MEM_MISALIGN_TRAP_EN, lw at 0x3001 -> no strobes, misalign=1, load_data_out=0. Without the macro -> read at 0x3000, misalign=0.
- XLEN=64, ld at 0x4000, rdata 0x8000_0000_0000_0001 -> load_data_out equals rdata. lwu at 0x4004 -> 0x0000_0000_8000_0000.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory access stage: FSM states,
// RISC-V funct3 width codes and the byte-mask / misalignment helpers.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Access size in bytes; doubleword collapses to word on 32-bit datapaths.
    function automatic logic [3:0] access_bytes(input logic [2:0] funct3, input logic is64);
        logic [3:0] bytes_v;
        case (funct3[1:0])
            2'b00:   bytes_v = 4'd1;
            2'b01:   bytes_v = 4'd2;
            2'b10:   bytes_v = 4'd4;
            2'b11:   bytes_v = is64 ? 4'd8 : 4'd4;
            default: bytes_v = 4'd4;
        endcase
        return bytes_v;
    endfunction

    function automatic logic [7:0] base_mask(input logic [2:0] funct3, input logic is64);
        logic [7:0] mask_v;
        case (access_bytes(funct3, is64))
            4'd1:    mask_v = 8'h01;
            4'd2:    mask_v = 8'h03;
            4'd4:    mask_v = 8'h0F;
            4'd8:    mask_v = 8'hFF;
            default: mask_v = 8'h0F;
        endcase
        return mask_v;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] offs,
                                           input logic is64);
        logic mis_v;
        case (access_bytes(funct3, is64))
            4'd1:    mis_v = 1'b0;
            4'd2:    mis_v = offs[0];
            4'd4:    mis_v = |offs[1:0];
            4'd8:    mis_v = |offs;
            default: mis_v = 1'b0;
        endcase
        return mis_v;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load data formatter: moves the addressed bytes down to bit 0, then
// sign- or zero-extends them according to the funct3 width code.
module load_extend_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int OFFS_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]   rdata,
    input  logic [OFFS_W-1:0] offset,
    input  logic [2:0]        funct3,
    output logic [XLEN-1:0]   result
);

    logic [XLEN-1:0] shifted_s;

    assign shifted_s = rdata >> {offset, 3'b000};

    // Width selection; on 32-bit builds ld and lwu degenerate to the full word.
    always_comb begin
        result = shifted_s;
        case (funct3)
            F3_LB:   result = XLEN'($signed(shifted_s[7:0]));
            F3_LH:   result = XLEN'($signed(shifted_s[15:0]));
            F3_LW:   result = XLEN'($signed(shifted_s[31:0]));
            F3_LD:   result = shifted_s;
            F3_LBU:  result = XLEN'(shifted_s[7:0]);
            F3_LHU:  result = XLEN'(shifted_s[15:0]);
            F3_LWU:  result = XLEN'(shifted_s[31:0]);
            default: result = shifted_s;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory stage: captures a load/store, drives the data cache until it
// responds and formats the result. MEM_MISALIGN_TRAP_EN turns misaligned accesses into traps.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter  int XLEN   = 32,
    localparam int LANES  = XLEN / 8,
    localparam int OFFS_W = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [2:0]        funct3_in,
    input  logic [XLEN-1:0]   addr_in,
    input  logic [XLEN-1:0]   store_data_in,
    input  logic              pipe_stall,
    input  logic [XLEN-1:0]   dcache_rdata,
    input  logic              dcache_resp,
    output logic              dcache_read,
    output logic              dcache_write,
    output logic [XLEN-1:0]   dcache_addr,
    output logic [LANES-1:0]  dcache_wmask,
    output logic [XLEN-1:0]   dcache_wdata,
    output logic [XLEN-1:0]   load_data_out,
    output logic              mem_stall,
    output logic              misalign
);

    localparam logic IS64 = (XLEN == 64);

    mem_state_t        state_r;
    mem_state_t        state_next_s;
    logic              access_s;
    logic              trap_s;
    logic              mem_stall_s;
    logic [OFFS_W-1:0] offset_s;
    logic [2:0]        offs3_s;
    logic [LANES-1:0]  mask_s;
    logic [XLEN-1:0]   aligned_addr_s;
    logic [XLEN-1:0]   shifted_wdata_s;
    logic [XLEN-1:0]   load_ext_s;

    logic [XLEN-1:0]   addr_r;
    logic [XLEN-1:0]   wdata_r;
    logic [LANES-1:0]  wmask_r;
    logic [2:0]        funct3_r;
    logic [OFFS_W-1:0] offs_r;
    logic              read_r;
    logic              write_r;
    logic [XLEN-1:0]   load_data_r;

    assign access_s        = valid_in & (mem_read_in | mem_write_in);
    assign offset_s        = addr_in[OFFS_W-1:0];
    assign offs3_s         = 3'(offset_s);
    // Lanes shifted past the top of the cache word are simply dropped.
    assign mask_s          = LANES'({8'h00, base_mask(funct3_in, IS64)} << offs3_s);
    assign aligned_addr_s  = {addr_in[XLEN-1:OFFS_W], {OFFS_W{1'b0}}};
    assign shifted_wdata_s = store_data_in << {offset_s, 3'b000};

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_s = is_misaligned(funct3_in, offs3_s, IS64);
`else
    assign trap_s = 1'b0;
`endif

    load_extend_unit #(
        .XLEN   (XLEN),
        .OFFS_W (OFFS_W)
    ) u_load_extend (
        .rdata  (dcache_rdata),
        .offset (offs_r),
        .funct3 (funct3_r),
        .result (load_ext_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and the stall request seen by the upstream stages
    always_comb begin
        state_next_s = state_r;
        mem_stall_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (access_s) begin
                    mem_stall_s  = 1'b1;
                    state_next_s = trap_s ? ST_DONE : ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                mem_stall_s = 1'b1;
                if (dcache_resp) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_DONE: begin
                if (pipe_stall) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Request capture, cache strobes and load result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r      <= {XLEN{1'b0}};
            wdata_r     <= {XLEN{1'b0}};
            wmask_r     <= {LANES{1'b0}};
            funct3_r    <= 3'b000;
            offs_r      <= {OFFS_W{1'b0}};
            read_r      <= 1'b0;
            write_r     <= 1'b0;
            load_data_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (access_s) begin
                        addr_r   <= aligned_addr_s;
                        funct3_r <= funct3_in;
                        offs_r   <= offset_s;
                        wdata_r  <= mem_write_in ? shifted_wdata_s : {XLEN{1'b0}};
                        wmask_r  <= mem_write_in ? mask_s : {LANES{1'b0}};
                        read_r   <= ~trap_s & ~mem_write_in;
                        write_r  <= ~trap_s & mem_write_in;
                        if (trap_s) begin
                            load_data_r <= {XLEN{1'b0}};
                        end
                    end
                end
                ST_REQ: begin
                    if (dcache_resp) begin
                        read_r  <= 1'b0;
                        write_r <= 1'b0;
                        if (read_r) begin
                            load_data_r <= load_ext_s;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_r;

    // Trap flag is raised for the whole DONE residency of a trapped access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (access_s) begin
                        misalign_r <= trap_s;
                    end
                end
                ST_DONE: begin
                    if (!pipe_stall) begin
                        misalign_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign misalign = misalign_r;
`else
    assign misalign = 1'b0;
`endif

    assign dcache_read   = read_r;
    assign dcache_write  = write_r;
    assign dcache_addr   = addr_r;
    assign dcache_wmask  = wmask_r;
    assign dcache_wdata  = wdata_r;
    assign load_data_out = load_data_r;
    assign mem_stall     = mem_stall_s;

endmodule
